// File: rtl/mccu_pkg.sv
// mccu_pkg: shared constants for the multi-cycle control unit.
// Opcode values, FSM state encodings, instruction classes, ALU function
// codes and PCSrc/RegDst selector codes.
package mccu_pkg;

    // Opcodes (6-bit instruction field)
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_OR    = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b011100;
    localparam logic [5:0] OP_BEQ   = 6'b110000;
    localparam logic [5:0] OP_BNE   = 6'b110001;
    localparam logic [5:0] OP_BLTZ  = 6'b110010;
    localparam logic [5:0] OP_SW    = 6'b100110;
    localparam logic [5:0] OP_LW    = 6'b100111;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // FSM states; HALT shares the IF encoding and is tracked by a flag
    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    // Instruction classes produced by the decoder
    typedef enum logic [2:0] {
        CLS_ILL, CLS_AL, CLS_BR, CLS_LS, CLS_J, CLS_JR, CLS_JAL, CLS_HALT
    } cls_t;

    // ALU function codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    // PCSrc selector
    localparam logic [1:0] PC_NEXT = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_RS   = 2'b10;
    localparam logic [1:0] PC_JUMP = 2'b11;

    // RegDst selector
    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

endpackage

// File: rtl/mccu_decode.sv
// mccu_decode: purely combinational opcode decoder.
// Maps an opcode to its instruction class and the ALU-side controls.
// MCCU_JAL_EN: when defined, jr/jal decode to their own classes;
// otherwise those opcodes fall into the illegal class.
module mccu_decode
    import mccu_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op,
    output cls_t            cls,
    output logic [2:0]      aluop,
    output logic            srca,
    output logic            srcb,
    output logic            ext,
    output logic            rd_sel
);

    // Opcode table: class, ALU function and operand selects
    always_comb begin
        cls    = CLS_ILL;
        aluop  = ALU_ADD;
        srca   = 1'b0;
        srcb   = 1'b0;
        ext    = 1'b1;
        rd_sel = 1'b0;
        case (op)
            OP_ADD:   begin cls = CLS_AL; rd_sel = 1'b1; end
            OP_SUB:   begin cls = CLS_AL; aluop = ALU_SUB; rd_sel = 1'b1; end
            OP_ADDIU: begin cls = CLS_AL; srcb = 1'b1; end
            OP_ANDI:  begin cls = CLS_AL; aluop = ALU_AND; srcb = 1'b1; ext = 1'b0; end
            OP_AND:   begin cls = CLS_AL; aluop = ALU_AND; rd_sel = 1'b1; end
            OP_ORI:   begin cls = CLS_AL; aluop = ALU_OR; srcb = 1'b1; ext = 1'b0; end
            OP_OR:    begin cls = CLS_AL; aluop = ALU_OR; rd_sel = 1'b1; end
            OP_SLL:   begin cls = CLS_AL; aluop = ALU_SLL; srca = 1'b1; ext = 1'b0; rd_sel = 1'b1; end
            OP_SLTI:  begin cls = CLS_AL; aluop = ALU_SLT; srcb = 1'b1; end
            OP_BEQ:   begin cls = CLS_BR; aluop = ALU_SUB; end
            OP_BNE:   begin cls = CLS_BR; aluop = ALU_SUB; end
            OP_BLTZ:  begin cls = CLS_BR; aluop = ALU_SLT; end
            OP_SW:    begin cls = CLS_LS; srcb = 1'b1; end
            OP_LW:    begin cls = CLS_LS; srcb = 1'b1; end
            OP_J:     cls = CLS_J;
            OP_HALT:  cls = CLS_HALT;
`ifdef MCCU_JAL_EN
            OP_JR:    cls = CLS_JR;
            OP_JAL:   cls = CLS_JAL;
`endif
            default:  cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// multi_cycle_control_unit: multi-cycle MIPS control FSM.
// Sequences IF/ID/EXE/MEM/WB and drives per-state datapath strobes.
// MEM is held MEM_WAIT extra cycles. MCCU_JAL_EN enables jr/jal.
// Every output is forced low while Reset is high.
module multi_cycle_control_unit
    import mccu_pkg::*;
#(
    parameter int OP_W     = 6,
    parameter int ALUOP_W  = 3,
    parameter int MEM_WAIT = 0
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [OP_W-1:0]    opCode,
    input  logic               zero,
    input  logic               sign,
    output logic               PCWre,
    output logic               IRWre,
    output logic               RegWre,
    output logic               InsMemRW,
    output logic               mRD,
    output logic               mWR,
    output logic               ALUSrcA,
    output logic               ALUSrcB,
    output logic               ExtSel,
    output logic               DBDataSrc,
    output logic [1:0]         RegDst,
    output logic [1:0]         PCSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [2:0]         state,
    output logic               illegal
);

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            halt_q, halt_d;
    logic            ill_q, ill_d;

    logic [OP_W-1:0] dec_op;
    cls_t            cls;
    logic [2:0]      dec_aluop;
    logic            dec_srca, dec_srcb, dec_ext, dec_rd;
    logic            is_sw, taken;

    // ID decodes the live opcode; later states decode the latched copy
    assign dec_op  = (state_q == S_ID) ? opCode : op_q;
    assign is_sw   = (op_q == OP_SW);
    assign state   = state_q;
    assign illegal = ill_q;

    mccu_decode #(.OP_W(OP_W)) u_decode (
        .op     (dec_op),
        .cls    (cls),
        .aluop  (dec_aluop),
        .srca   (dec_srca),
        .srcb   (dec_srcb),
        .ext    (dec_ext),
        .rd_sel (dec_rd)
    );

    // Branch condition from the latched opcode and ALU flags
    always_comb begin
        taken = 1'b0;
        case (op_q)
            OP_BEQ:  taken = zero;
            OP_BNE:  taken = !zero;
            OP_BLTZ: taken = sign;
            default: taken = 1'b0;
        endcase
    end

    // State, latched opcode, MEM wait counter and sticky flags
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IF;
            op_q    <= '0;
            cnt_q   <= '0;
            halt_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            halt_q  <= halt_d;
            ill_q   <= ill_d;
        end
    end

    // Next-state and per-state strobes, all masked while Reset is high
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        halt_d    = halt_q;
        ill_d     = ill_q;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        InsMemRW  = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        DBDataSrc = 1'b0;
        RegDst    = RD_RT;
        PCSrc     = PC_NEXT;
        ALUOp     = '0;
        if (!halt_q) begin
            if (state_q == S_EXE_AL || state_q == S_EXE_BR || state_q == S_EXE_LS) begin
                ALUOp   = ALUOP_W'(dec_aluop);
                ALUSrcA = dec_srca;
                ALUSrcB = dec_srcb;
                ExtSel  = dec_ext;
            end
            case (state_q)
                S_IF: begin
                    IRWre    = 1'b1;
                    InsMemRW = 1'b1;
                    state_d  = S_ID;
                end
                S_ID: begin
                    op_d    = opCode;
                    state_d = S_IF;
                    case (cls)
                        CLS_AL:   state_d = S_EXE_AL;
                        CLS_BR:   state_d = S_EXE_BR;
                        CLS_LS:   state_d = S_EXE_LS;
                        CLS_J:    begin PCWre = 1'b1; PCSrc = PC_JUMP; end
                        CLS_JR:   begin PCWre = 1'b1; PCSrc = PC_RS; end
                        CLS_JAL:  begin
                            PCWre  = 1'b1;
                            PCSrc  = PC_JUMP;
                            RegWre = 1'b1;
                            RegDst = RD_R31;
                        end
                        CLS_HALT: halt_d = 1'b1;
                        default:  begin PCWre = 1'b1; ill_d = 1'b1; end
                    endcase
                end
                S_EXE_AL: state_d = S_WB_AL;
                S_WB_AL: begin
                    RegWre  = 1'b1;
                    PCWre   = 1'b1;
                    RegDst  = dec_rd ? RD_RD : RD_RT;
                    state_d = S_IF;
                end
                S_EXE_BR: begin
                    PCWre   = 1'b1;
                    PCSrc   = taken ? PC_BR : PC_NEXT;
                    state_d = S_IF;
                end
                S_EXE_LS: begin
                    cnt_d   = 4'(MEM_WAIT);
                    state_d = S_MEM;
                end
                S_MEM: begin
                    mWR = is_sw;
                    mRD = !is_sw;
                    if (cnt_q == 4'd0) begin
                        if (is_sw) begin
                            PCWre   = 1'b1;
                            state_d = S_IF;
                        end else begin
                            state_d = S_WB_LD;
                        end
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_WB_LD: begin
                    RegWre    = 1'b1;
                    DBDataSrc = 1'b1;
                    PCWre     = 1'b1;
                    state_d   = S_IF;
                end
                default: state_d = S_IF;
            endcase
        end
        if (Reset) begin
            PCWre     = 1'b0;
            IRWre     = 1'b0;
            RegWre    = 1'b0;
            InsMemRW  = 1'b0;
            mRD       = 1'b0;
            mWR       = 1'b0;
            ALUSrcA   = 1'b0;
            ALUSrcB   = 1'b0;
            ExtSel    = 1'b0;
            DBDataSrc = 1'b0;
            RegDst    = RD_RT;
            PCSrc     = PC_NEXT;
            ALUOp     = '0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// tb_multi_cycle_control_unit: scoreboard bench for the multi-cycle control unit.
// The driver pushes the expected per-cycle output trace of each instruction;
// a negedge monitor pops and compares one entry per cycle.
module tb_multi_cycle_control_unit;

    localparam int MW = 2;
    localparam int W  = 21;

    localparam int K_ILL = 0, K_AL = 1, K_BR = 2, K_LS = 3;
    localparam int K_J = 4, K_JR = 5, K_JAL = 6, K_HALT = 7;

    typedef struct packed {
        logic [2:0] st;
        logic       pcwre, irwre, regwre, insmem, mrd, mwr;
        logic       srca, srcb, ext, dbsrc;
        logic [1:0] regdst, pcsrc;
        logic [2:0] aluop;
        logic       ill;
    } obs_t;

    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic [5:0] opCode = '0;
    logic       zero = 1'b0, sign = 1'b0;
    logic       PCWre, IRWre, RegWre, InsMemRW, mRD, mWR;
    logic       ALUSrcA, ALUSrcB, ExtSel, DBDataSrc;
    logic [1:0] RegDst, PCSrc;
    logic [2:0] ALUOp, state;
    logic       illegal;

    logic [W-1:0] obs;
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;
    bit           m_ill = 1'b0;

    multi_cycle_control_unit #(.OP_W(6), .ALUOP_W(3), .MEM_WAIT(MW)) dut (
        .CLK(CLK), .Reset(Reset), .opCode(opCode), .zero(zero), .sign(sign),
        .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .InsMemRW(InsMemRW),
        .mRD(mRD), .mWR(mWR), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ExtSel(ExtSel), .DBDataSrc(DBDataSrc), .RegDst(RegDst), .PCSrc(PCSrc),
        .ALUOp(ALUOp), .state(state), .illegal(illegal)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    assign obs = {state, PCWre, IRWre, RegWre, InsMemRW, mRD, mWR,
                  ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, RegDst, PCSrc, ALUOp, illegal};

    task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%b required=%b (t=%0t)", nm, got, want, $time);
        end
    endtask

    // monitor: one expected entry per cycle whenever the scoreboard holds any
    always @(negedge CLK) begin : monitor
        logic [W-1:0] e;
        string        n;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, obs, e);
        end
    end

    // ---------------- reference model ----------------
    function automatic obs_t blank(input logic [2:0] st);
        obs_t r;
        r     = '0;
        r.st  = st;
        r.ill = m_ill;
        return r;
    endfunction

    task automatic push(input obs_t r, input string n);
        exp_q.push_back(r);
        name_q.push_back(n);
    endtask

    task automatic ref_class(input logic [5:0] op, output int k, output logic [2:0] a,
                             output logic sa, output logic sb, output logic ex, output logic rd);
        k = K_ILL; a = 3'd0; sa = 0; sb = 0; ex = 1; rd = 0;
        case (op)
            6'b000000: begin k = K_AL; rd = 1; end
            6'b000001: begin k = K_AL; a = 3'd1; rd = 1; end
            6'b000010: begin k = K_AL; sb = 1; end
            6'b010000: begin k = K_AL; a = 3'd4; sb = 1; ex = 0; end
            6'b010001: begin k = K_AL; a = 3'd4; rd = 1; end
            6'b010010: begin k = K_AL; a = 3'd3; sb = 1; ex = 0; end
            6'b010011: begin k = K_AL; a = 3'd3; rd = 1; end
            6'b011000: begin k = K_AL; a = 3'd2; sa = 1; ex = 0; rd = 1; end
            6'b011100: begin k = K_AL; a = 3'd6; sb = 1; end
            6'b110000, 6'b110001: begin k = K_BR; a = 3'd1; end
            6'b110010: begin k = K_BR; a = 3'd6; end
            6'b100110, 6'b100111: begin k = K_LS; sb = 1; end
            6'b111000: k = K_J;
            6'b111111: k = K_HALT;
`ifdef MCCU_JAL_EN
            6'b111001: k = K_JR;
            6'b111010: k = K_JAL;
`endif
            default: k = K_ILL;
        endcase
    endtask

    // Expected trace of one instruction starting in IF; n = cycles it occupies
    task automatic model_instr(input logic [5:0] op, input logic z, input logic s,
                               input int hold, output int n);
        int k;
        logic [2:0] a;
        logic sa, sb, ex, rd, tk;
        obs_t r;
        ref_class(op, k, a, sa, sb, ex, rd);
        r = blank(3'b000); r.irwre = 1; r.insmem = 1; push(r, "fetch");
        r = blank(3'b001);
        case (k)
            K_J:   begin r.pcwre = 1; r.pcsrc = 2'b11; end
            K_JR:  begin r.pcwre = 1; r.pcsrc = 2'b10; end
            K_JAL: begin r.pcwre = 1; r.pcsrc = 2'b11; r.regwre = 1; r.regdst = 2'b10; end
            K_ILL: r.pcwre = 1;
            default: ;
        endcase
        push(r, "decode");
        n = 2;
        if (k == K_ILL) m_ill = 1'b1;
        case (k)
            K_AL: begin
                r = blank(3'b110); r.aluop = a; r.srca = sa; r.srcb = sb; r.ext = ex;
                push(r, "alu_exe");
                r = blank(3'b111); r.regwre = 1; r.pcwre = 1; r.regdst = rd ? 2'b01 : 2'b00;
                push(r, "alu_wb");
                n += 2;
            end
            K_BR: begin
                tk = (op == 6'b110000 && z) || (op == 6'b110001 && !z) || (op == 6'b110010 && s);
                r = blank(3'b101); r.aluop = a; r.srca = sa; r.srcb = sb; r.ext = ex;
                r.pcwre = 1; r.pcsrc = tk ? 2'b01 : 2'b00;
                push(r, "branch");
                n += 1;
            end
            K_LS: begin
                r = blank(3'b010); r.aluop = a; r.srca = sa; r.srcb = sb; r.ext = ex;
                push(r, "ls_exe");
                n += 1;
                for (int i = 0; i <= MW; i++) begin
                    r = blank(3'b011);
                    if (op == 6'b100110) begin
                        r.mwr = 1;
                        r.pcwre = (i == MW);
                    end else begin
                        r.mrd = 1;
                    end
                    push(r, "mem");
                    n += 1;
                end
                if (op == 6'b100111) begin
                    r = blank(3'b100); r.regwre = 1; r.dbsrc = 1; r.pcwre = 1;
                    push(r, "load_wb");
                    n += 1;
                end
            end
            K_HALT: begin
                for (int i = 0; i < hold; i++) begin
                    push(blank(3'b000), "halted");
                    n += 1;
                end
            end
            default: ;
        endcase
    endtask

    // ---------------- driver tasks ----------------
    // Called one time unit after a rising edge with the DUT in IF
    task automatic issue(input logic [5:0] op, input logic z, input logic s);
        int n;
        model_instr(op, z, s, 0, n);
        opCode = op; zero = z; sign = s;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int k);
        Reset = 1'b1;
        #1;
        check("reset_outputs", obs, '0);
        m_ill = 1'b0;
        for (int i = 0; i < k; i++) push(blank(3'b000), "in_reset");
        repeat (k) @(posedge CLK);
        #1;
        Reset = 1'b0;
    endtask

    logic [5:0] pool [17] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                              6'b010010, 6'b010011, 6'b011000, 6'b011100, 6'b110000,
                              6'b110001, 6'b110010, 6'b100110, 6'b100111, 6'b111000,
                              6'b111001, 6'b111010};

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic [5:0] op;
        @(posedge CLK); #1;
        do_reset(3);

        issue(6'b000000, 0, 0);             // add
        issue(6'b110000, 1, 0);             // beq taken
        issue(6'b110001, 1, 0);             // bne not taken
        issue(6'b110010, 0, 1);             // bltz taken
        issue(6'b100111, 0, 0);             // lw
        issue(6'b100110, 0, 0);             // sw
        issue(6'b011000, 0, 0);             // sll
        issue(6'b111000, 0, 0);             // j
        issue(6'b111001, 0, 0);             // jr
        issue(6'b111010, 0, 0);             // jal
        issue(6'b101010, 0, 0);             // illegal
        issue(6'b000001, 0, 0);             // sub with illegal still set
        do_reset(2);
        issue(6'b010010, 0, 0);             // ori after reset

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom_range(0, 62));
            end else begin
                op = pool[$urandom_range(0, 16)];
            end
            issue(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // reset in the first MEM cycle of a sw
        do_reset(1);
        model_instr(6'b100110, 0, 0, 0, n);
        for (int i = 0; i < MW; i++) begin
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
        end
        opCode = 6'b100110;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        #2;
        Reset = 1'b1;
        #1;
        check("reset_abort", obs, '0);
        m_ill = 1'b0;
        push(blank(3'b000), "in_reset");
        push(blank(3'b000), "in_reset");
        repeat (3) @(posedge CLK);
        #1;
        Reset = 1'b0;

        // halt held for 20 cycles, then recovered by reset
        model_instr(6'b111111, 0, 0, 20, n);
        opCode = 6'b111111;
        repeat (n) @(posedge CLK);
        #1;
        do_reset(2);
        issue(6'b000000, 0, 0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: got=%0d required=0 entries left", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
